fmap_reader: RTL and testbench

Read-back engine for convolution output feature maps. The accumulator stage writes one clamped signed 8-bit result per output pixel into feature-map RAM at address i*W + j. This block is the opposite end of that interface: on a start pulse it walks the map in raster order and issues synchronous RAM reads. It streams each pixel, tagged with its (i, j) coordinate, over a valid/ready interface to the next layer (pooling or dense), with full throughput and lossless backpressure.

---
 rtl/fmap_reader.sv | 123 ++++++++++++
 tb/tb_fmap_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_reader.sv
// fmap_reader: raster-order feature-map RAM reader streaming (i, j, pixel) beats over valid/ready.
module fmap_reader #(
    parameter int W        = 28,
    parameter int H        = 28,
    parameter int ADDR_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_LEN:0] mem_addr,
    input  logic signed [7:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] out_data,
    output logic [4:0]        out_i,
    output logic [4:0]        out_j,
    output logic              out_last
);
    localparam int AW = ADDR_LEN + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [4:0]        ri_q, ri_d, rj_q, rj_d, ti_q, ti_d, tj_q, tj_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        count_q, count_d;
    logic              wp_q, wp_d, rp_q, rp_d;
    logic signed [7:0] fd_q [2];
    logic signed [7:0] fd_d [2];
    logic [4:0]        fi_q [2];
    logic [4:0]        fi_d [2];
    logic [4:0]        fj_q [2];
    logic [4:0]        fj_d [2];
    logic              push, pop, can_issue, last_rd;

    assign busy      = state_q != IDLE;
    assign mem_addr  = addr_q;
    assign out_valid = count_q != 2'd0;
    assign out_data  = fd_q[rp_q];
    assign out_i     = fi_q[rp_q];
    assign out_j     = fj_q[rp_q];
    assign out_last  = out_valid && fi_q[rp_q] == 5'(H - 1) && fj_q[rp_q] == 5'(W - 1);

    always_comb begin
        pop        = out_valid && out_ready;
        push       = inflight_q;
        // Occupancy plus the read in flight must never exceed the two FIFO slots.
        can_issue  = ({1'b0, count_q} + {2'b0, inflight_q} < 3'd2) || pop;
        last_rd    = ri_q == 5'(H - 1) && rj_q == 5'(W - 1);
        mem_re     = state_q == RUN && can_issue;
        done       = state_q == DRAIN && count_q == 2'd0 && !inflight_q;
        state_d    = state_q;
        ri_d       = ri_q;
        rj_d       = rj_q;
        addr_d     = addr_q;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            ri_d    = '0;
            rj_d    = '0;
            addr_d  = '0;
        end
        if (mem_re) begin
            if (last_rd) begin
                state_d = DRAIN;
            end else begin
                rj_d   = rj_q == 5'(W - 1) ? 5'd0 : rj_q + 5'd1;
                ri_d   = rj_q == 5'(W - 1) ? ri_q + 5'd1 : ri_q;
                addr_d = addr_q + AW'(1);
            end
        end
        if (done) state_d = IDLE;
        ti_d       = mem_re ? ri_q : ti_q;
        tj_d       = mem_re ? rj_q : tj_q;
        inflight_d = mem_re;
        fd_d       = fd_q;
        fi_d       = fi_q;
        fj_d       = fj_q;
        if (push) begin
            fd_d[wp_q] = mem_rdata;
            fi_d[wp_q] = ti_q;
            fj_d[wp_q] = tj_q;
        end
        wp_d       = wp_q ^ push;
        rp_d       = rp_q ^ pop;
        count_d    = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ri_q       <= '0;
            rj_q       <= '0;
            ti_q       <= '0;
            tj_q       <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            fd_q       <= '{default: '0};
            fi_q       <= '{default: '0};
            fj_q       <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ri_q       <= ri_d;
            rj_q       <= rj_d;
            ti_q       <= ti_d;
            tj_q       <= tj_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            fd_q       <= fd_d;
            fi_q       <= fi_d;
            fj_q       <= fj_d;
        end
    end
endmodule

// File: tb/tb_fmap_reader.sv
// tb_fmap_reader: drives a 4x4 and a 28x28 reader against RAM models and a raster-order scoreboard.
module tb_fmap_reader;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              out_ready = 1'b0;
    logic              start [2];
    logic              busy [2];
    logic              done [2];
    logic              mem_re [2];
    logic [9:0]        addr [2];
    logic [3:0]        a4;
    logic [9:0]        a28;
    logic signed [7:0] mem_rdata [2];
    logic              out_valid [2];
    logic signed [7:0] out_data [2];
    logic [4:0]        out_i [2];
    logic [4:0]        out_j [2];
    logic              out_last [2];
    logic signed [7:0] ram [2][1024];

    int cyc = 0;
    int n_vec = 0, n_err = 0;
    int exp_beat [2], issued [2], popped [2], done_cnt [2], done_cyc [2];
    int first_cyc [2], last_cyc [2], t0 [2];
    bit act [2];
    bit pv_stall [2];
    logic signed [7:0] pv_data [2];
    logic [4:0] pv_i [2], pv_j [2];

    typedef struct {
        int inst;
        int fill;
        int rmode;
        bit dup;
        int tail;
        int exp_done;
    } scen_t;
    scen_t tbl [7];

    fmap_reader #(.W(4), .H(4), .ADDR_LEN(3)) u4 (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .mem_re(mem_re[0]), .mem_addr(a4), .mem_rdata(mem_rdata[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_i(out_i[0]), .out_j(out_j[0]), .out_last(out_last[0]));

    fmap_reader u28 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .mem_re(mem_re[1]), .mem_addr(a28), .mem_rdata(mem_rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_i(out_i[1]), .out_j(out_j[1]), .out_last(out_last[1]));

    assign addr[0] = {6'b0, a4};
    assign addr[1] = a28;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++)
            if (mem_re[k]) mem_rdata[k] <= ram[k][addr[k]];
    end

    function automatic int nmap(int k);
        return k != 0 ? 784 : 16;
    endfunction

    function automatic int wid(int k);
        return k != 0 ? 28 : 4;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, got, want);
        end
    endtask

    task automatic mon(input int k);
        int rel, e;
        if (!act[k]) return;
        rel = cyc - t0[k];
        chk("busy", int'(busy[k]), int'(rel >= 1 && done_cnt[k] == 0));
        if (mem_re[k]) begin
            chk("rd_addr", int'(addr[k]), issued[k]);
            chk("room", int'((issued[k] - popped[k] < 2) || (out_valid[k] && out_ready)), 1);
            issued[k]++;
        end
        if (pv_stall[k]) begin
            chk("stall_valid", int'(out_valid[k]), 1);
            chk("stall_data", int'(out_data[k]), int'(pv_data[k]));
            chk("stall_i", int'(out_i[k]), int'(pv_i[k]));
            chk("stall_j", int'(out_j[k]), int'(pv_j[k]));
        end
        if (out_valid[k] && out_ready) begin
            e = exp_beat[k];
            chk("data", int'(out_data[k]), int'(ram[k][e % 1024]));
            chk("out_i", int'(out_i[k]), e / wid(k));
            chk("out_j", int'(out_j[k]), e % wid(k));
            chk("out_last", int'(out_last[k]), int'(e == nmap(k) - 1));
            if (e == 0) first_cyc[k] = rel;
            if (e == nmap(k) - 1) last_cyc[k] = rel;
            exp_beat[k]++;
            popped[k]++;
        end
        pv_stall[k] = out_valid[k] && !out_ready;
        pv_data[k]  = out_data[k];
        pv_i[k]     = out_i[k];
        pv_j[k]     = out_j[k];
        if (done[k]) begin
            done_cnt[k]++;
            done_cyc[k] = rel;
        end
    endtask

    always @(negedge clk) for (int k = 0; k < 2; k++) mon(k);

    task automatic fill(input int k, input int mode);
        for (int a = 0; a < 1024; a++)
            if (mode == 0) ram[k][a] = 8'(a - 8);
            else if (mode == 2) ram[k][a] = (a % 2 != 0) ? -8'sd128 : 8'sd127;
            else ram[k][a] = 8'($urandom);
    endtask

    function automatic logic ready_for(input int rmode, input int rel);
        if (rmode == 1) return (rel % 4 == 0) || (rel % 4 == 3);
        if (rmode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic launch(input int k);
        exp_beat[k] = 0; issued[k] = 0; popped[k] = 0; done_cnt[k] = 0;
        done_cyc[k] = -1; first_cyc[k] = -1; last_cyc[k] = -1; pv_stall[k] = 0;
        t0[k] = cyc;
        act[k] = 1;
        start[k] = 1'b1;
    endtask

    task automatic run_map(input int k, input int rmode, input bit dup, input int tail);
        int n = 0, rel;
        launch(k);
        out_ready = ready_for(rmode, 0);
        @(posedge clk); #1;
        start[k] = 1'b0;
        while (done_cnt[k] == 0 && n < 20000) begin
            rel = cyc - t0[k];
            out_ready = ready_for(rmode, rel);
            start[k] = dup && (rel == 5 || rel == 12);
            @(posedge clk); #1;
            start[k] = 1'b0;
            n++;
        end
        if (n == 20000) chk("timeout", done_cnt[k], 1);
        out_ready = 1'b1;
        repeat (tail) begin
            @(posedge clk); #1;
        end
        if (tail > 0) act[k] = 0;
    endtask

    task automatic post(input int k, input int exp_done);
        chk("beats", exp_beat[k], nmap(k));
        chk("reads", issued[k], nmap(k));
        chk("dones", done_cnt[k], 1);
        if (exp_done >= 0) begin
            chk("done_cyc", done_cyc[k], exp_done);
            chk("last_cyc", last_cyc[k], exp_done - 1);
            chk("first_cyc", first_cyc[k], 3);
        end
    endtask

    task automatic chk_reset(input int k);
        chk("rst_busy", int'(busy[k]), 0);
        chk("rst_done", int'(done[k]), 0);
        chk("rst_mem_re", int'(mem_re[k]), 0);
        chk("rst_addr", int'(addr[k]), 0);
        chk("rst_valid", int'(out_valid[k]), 0);
        chk("rst_data", int'(out_data[k]), 0);
        chk("rst_i", int'(out_i[k]), 0);
        chk("rst_j", int'(out_j[k]), 0);
        chk("rst_last", int'(out_last[k]), 0);
    endtask

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        act[0] = 0; act[1] = 0;
        tbl[0] = '{0,  0, 0, 1'b0, 3, 19};
        tbl[1] = '{0,  1, 1, 1'b0, 3, -1};
        tbl[2] = '{1,  1, 0, 1'b0, 3, 787};
        tbl[3] = '{0,  2, 0, 1'b1, 3, 19};
        tbl[4] = '{1,  2, 2, 1'b0, 3, -1};
        tbl[5] = '{0,  1, 2, 1'b0, 0, -1};
        tbl[6] = '{0, -1, 2, 1'b0, 3, -1};
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 7; s++) begin
            if (tbl[s].fill >= 0) fill(tbl[s].inst, tbl[s].fill);
            run_map(tbl[s].inst, tbl[s].rmode, tbl[s].dup, tbl[s].tail);
            post(tbl[s].inst, tbl[s].exp_done);
        end

        // Reset lands during the fifth beat; the map is abandoned without done.
        fill(0, 1);
        launch(0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        act[0] = 0;
        chk("pre_rst_beats", exp_beat[0], 5);
        chk_reset(0);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_done", int'(done[0]), 0);
            chk("post_rst_busy", int'(busy[0]), 0);
        end
        run_map(0, 0, 1'b0, 3);
        post(0, 19);

        // Reset outranks a simultaneous start.
        rst = 1'b1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start[0] = 1'b0;
        chk("rst_vs_start_busy", int'(busy[0]), 0);
        @(posedge clk); #1;
        chk("rst_vs_start_busy2", int'(busy[0]), 0);
        chk("rst_vs_start_re", int'(mem_re[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
